// File: rtl/display_arbiter.sv
// display_arbiter: shares the 2-digit hex display between three requesters
// (0 = CPU output register, 1 = UART monitor, 2 = debug/single-step unit).
// Round-robin ownership with a minimum dwell time per owner. The last shown
// value is held whenever nobody owns the display.
module display_arbiter #(
  parameter int unsigned MIN_HOLD   = 2500000,
  parameter logic [7:0]  IDLE_VALUE = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_req,
  input  logic [7:0] i_data0,
  input  logic [7:0] i_data1,
  input  logic [7:0] i_data2,
  output logic [2:0] o_grant,
  output logic [1:0] o_owner,
  output logic       o_busy,
  output logic [7:0] o_data
);

  localparam int unsigned     CW       = $clog2(MIN_HOLD + 1);
  localparam logic [CW-1:0]   HOLD_MAX = CW'(MIN_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_LINGER = 2'd2
  } state_e;

  state_e        state_q,  state_d;
  logic [2:0]    grant_q,  grant_d;
  logic [1:0]    owner_q,  owner_d;
  logic [1:0]    last_q,   last_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          busy_q,   busy_d;
  logic [7:0]    data_q,   data_d;

  logic [1:0]    winner;
  logic          hold_done;
  logic [CW-1:0] cnt_inc;
  logic          owner_req;
  logic          others_req;
  logic [7:0]    owner_data;

  // Round-robin winner: search last+1, last+2, then last itself.
  always_comb begin
    winner = last_q;
    unique case (last_q)
      2'd0: begin
        if      (i_req[1]) winner = 2'd1;
        else if (i_req[2]) winner = 2'd2;
        else               winner = 2'd0;
      end
      2'd1: begin
        if      (i_req[2]) winner = 2'd2;
        else if (i_req[0]) winner = 2'd0;
        else               winner = 2'd1;
      end
      default: begin
        if      (i_req[0]) winner = 2'd0;
        else if (i_req[1]) winner = 2'd1;
        else               winner = 2'd2;
      end
    endcase
  end

  // Dwell counter status and current-owner request/data selection.
  always_comb begin
    hold_done  = (cnt_q == HOLD_MAX);
    cnt_inc    = hold_done ? cnt_q : cnt_q + CW'(1);
    // In OWN the grant vector is the owner's one-hot, so masking it out
    // leaves only the competing requests.
    others_req = |(i_req & ~grant_q);
    owner_req  = |(i_req & grant_q);
    unique case (owner_q)
      2'd0:    owner_data = i_data0;
      2'd1:    owner_data = i_data1;
      default: owner_data = i_data2;
    endcase
  end

  // Next-state and next-output computation for the ownership FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned; a missing default in always_comb infers a latch.
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    data_d  = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          state_d = ST_OWN;
          grant_d = 3'b001 << winner;
          owner_d = winner;
          last_d  = winner;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      ST_OWN: begin
        // The owner's value is captured on every OWN edge, including the
        // edge that leaves OWN, so the display ends on its final value.
        data_d = owner_data;
        if (hold_done && others_req) begin
          grant_d = 3'b001 << winner;
          owner_d = winner;
          last_d  = winner;
          cnt_d   = '0;
        end else if (!owner_req && !hold_done) begin
          state_d = ST_LINGER;
          grant_d = 3'b000;
          cnt_d   = cnt_inc;
        end else if (!owner_req) begin
          state_d = ST_IDLE;
          grant_d = 3'b000;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_LINGER: begin
        if (hold_done) begin
          if (|i_req) begin
            state_d = ST_OWN;
            grant_d = 3'b001 << winner;
            owner_d = winner;
            last_d  = winner;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 3'b000;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: registers use non-blocking assignments so all of them update
    // together from the values computed before the edge.
    if (i_reset) begin
      state_q <= ST_IDLE;
      grant_q <= 3'b000;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      data_q  <= IDLE_VALUE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  assign o_grant = grant_q;
  assign o_owner = owner_q;
  assign o_busy  = busy_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed and randomized stimulus for display_arbiter,
// compared every cycle against a behavioural model that tracks ownership as
// "who owns, how long since the grant, who was granted last".
module tb_display_arbiter;

  localparam int         MIN_HOLD   = 4;
  localparam logic [7:0] IDLE_VALUE = 8'hEE;

  localparam int M_IDLE   = 0;
  localparam int M_OWN    = 1;
  localparam int M_LINGER = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [7:0] d0, d1, d2;
  logic [2:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;

  // Model state
  int         m_mode;
  int         m_owner;
  int         m_last;
  int         m_age;
  logic [7:0] m_shown;

  display_arbiter #(
    .MIN_HOLD   (MIN_HOLD),
    .IDLE_VALUE (IDLE_VALUE)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_req   (req),
    .i_data0 (d0),
    .i_data1 (d1),
    .i_data2 (d2),
    .o_grant (grant),
    .o_owner (owner),
    .o_busy  (busy),
    .o_data  (data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] data_of(input int n);
    case (n)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  // First requester found walking forward from the last one granted.
  function automatic int pick();
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (req[c]) return c;
    end
    return m_last;
  endfunction

  task automatic grant_to(input int w);
    m_mode  = M_OWN;
    m_owner = w;
    m_last  = w;
    m_age   = 0;
  endtask

  // Advance the model by one clock edge using the inputs present now.
  task automatic model_step();
    bit done;
    bit mine;
    bit rivals;
    if (rst) begin
      m_mode  = M_IDLE;
      m_owner = 0;
      m_last  = 2;
      m_age   = 0;
      m_shown = IDLE_VALUE;
    end else begin
      done = (m_age >= MIN_HOLD - 1);
      case (m_mode)
        M_IDLE: if (req != 3'b000) grant_to(pick());
        M_OWN: begin
          m_shown = data_of(m_owner);
          mine    = req[m_owner];
          rivals  = ((req & ~(3'b001 << m_owner)) != 3'b000);
          if (done && rivals)      grant_to(pick());
          else if (!mine && !done) begin m_mode = M_LINGER; m_age++; end
          else if (!mine)          m_mode = M_IDLE;
          else                     m_age++;
        end
        default: begin
          if (done) begin
            if (req != 3'b000) grant_to(pick());
            else               m_mode = M_IDLE;
          end else begin
            m_age++;
          end
        end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    logic [2:0] g;
    g = (m_mode == M_OWN) ? 3'(1 << m_owner) : 3'b000;
    check({tag, ".grant"}, {5'd0, grant}, {5'd0, g});
    check({tag, ".owner"}, {6'd0, owner}, 8'(m_owner));
    check({tag, ".busy"},  {7'd0, busy},  {7'd0, (m_mode != M_IDLE)});
    check({tag, ".data"},  data,          m_shown);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    rst = 1'b1; req = 3'b111; d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;

    // Reset held with all requests asserted: no grant may appear.
    repeat (3) tick("reset");
    check("reset.grant_const", {5'd0, grant}, 8'h00);
    check("reset.data_const",  data, 8'hEE);
    check("reset.busy_const",  {7'd0, busy}, 8'h00);
    rst = 1'b0; req = 3'b000;
    tick("idle_after_reset");

    // Single owner: grant, then data one cycle later, then tracking.
    req = 3'b010; d1 = 8'h3C;
    tick("single.grant");
    check("single.grant_const", {5'd0, grant}, 8'h02);
    tick("single.first_data");
    check("single.data_3c", data, 8'h3C);
    d1 = 8'h5A;
    tick("single.track");
    check("single.data_5a", data, 8'h5A);
    repeat (18) tick("single.hold");
    check("single.still_owner", {5'd0, grant}, 8'h02);
    req = 3'b000;
    repeat (2) tick("single.release");
    check("single.idle_busy", {7'd0, busy}, 8'h00);

    // Round-robin with everyone requesting, 4-cycle slots.
    rst = 1'b1; tick("rr.reset");
    rst = 1'b0; req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        tick("rr");
        check("rr.grant_seq", {5'd0, grant}, 8'(1 << (r % 3)));
        check("rr.owner_seq", {6'd0, owner}, 8'(r % 3));
      end
    end

    // Early release by requester 0 while requester 2 waits.
    rst = 1'b1; tick("early.reset");
    rst = 1'b0; req = 3'b101; d0 = 8'h11; d2 = 8'hD2;
    tick("early.grant");
    check("early.grant0", {5'd0, grant}, 8'h01);
    tick("early.own");
    req = 3'b100; d0 = 8'h22;
    tick("early.linger_entry");
    check("early.no_grant", {5'd0, grant}, 8'h00);
    check("early.last_data", data, 8'h22);
    d0 = 8'h99;
    tick("early.linger");
    check("early.frozen", data, 8'h22);
    check("early.busy_linger", {7'd0, busy}, 8'h01);
    tick("early.regrant");
    check("early.grant2", {5'd0, grant}, 8'h04);
    tick("early.data2");

    // Owner drops and re-requests inside its hold window.
    rst = 1'b1; tick("relinger.reset");
    rst = 1'b0; req = 3'b010; d1 = 8'h44;
    tick("relinger.grant");
    req = 3'b000;
    tick("relinger.drop");
    req = 3'b010;
    tick("relinger.wait1");
    check("relinger.no_grant1", {5'd0, grant}, 8'h00);
    tick("relinger.wait2");
    check("relinger.no_grant2", {5'd0, grant}, 8'h00);
    tick("relinger.regrant");
    check("relinger.grant1", {5'd0, grant}, 8'h02);

    // Idle retention after a sole owner releases.
    rst = 1'b1; tick("retain.reset");
    rst = 1'b0; req = 3'b001; d0 = 8'h7F;
    repeat (7) tick("retain.own");
    req = 3'b000;
    tick("retain.release");
    d0 = 8'h00; d1 = 8'h01; d2 = 8'h02;
    for (int i = 0; i < 10; i++) begin
      tick("retain.idle");
      check("retain.data_7f", data, 8'h7F);
      check("retain.grant0", {5'd0, grant}, 8'h00);
      check("retain.busy0", {7'd0, busy}, 8'h00);
    end

    // Randomized traffic with requests that persist for several cycles.
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 2)] ^= 1'b1;
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
